// File: rtl/packed_adc_unpacker_if.sv
// Stream bundle for packed_adc_unpacker: packed dual-lane ADC input, {lane2,lane1} output, clip status.
// The clip counters are only present when PACKED_ADC_CLIP_COUNT_EN is defined.
interface packed_adc_unpacker_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int OUT_WIDTH        = 16
);
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
  logic                        S_AXIS_tvalid;
  logic                        S_AXIS_tready;
  logic [2*OUT_WIDTH-1:0]      M_AXIS_tdata;
  logic                        M_AXIS_tvalid;
  logic                        M_AXIS_tready;
  logic                        clip_clear;
  logic [1:0]                  clip_flags;
`ifdef PACKED_ADC_CLIP_COUNT_EN
  logic [31:0]                 clip_count_ch1;
  logic [31:0]                 clip_count_ch2;
`endif

  modport slave (
    input  S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready, clip_clear,
    output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, clip_flags
`ifdef PACKED_ADC_CLIP_COUNT_EN
    , output clip_count_ch1, clip_count_ch2
`endif
  );

  modport master (
    output S_AXIS_tdata, S_AXIS_tvalid, M_AXIS_tready, clip_clear,
    input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, clip_flags
`ifdef PACKED_ADC_CLIP_COUNT_EN
    , input clip_count_ch1, clip_count_ch2
`endif
  );
endinterface

// File: rtl/packed_adc_unpacker.sv
// Splits packed dual-lane ADC words into sign-extended lanes, block-averages 2^DEC_LOG2 beats,
// flags full-scale clipping. Optional per-lane clip counters: PACKED_ADC_CLIP_COUNT_EN.
module packed_adc_unpacker #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_DATA_WIDTH  = 16,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int OUT_WIDTH        = 16,
  parameter int DEC_LOG2         = 0
) (
  input logic                  adc_clk,
  input logic                  adc_rstn,
  packed_adc_unpacker_if.slave bus
);
  localparam int AW = ADC_WIDTH + DEC_LOG2;
  localparam int CW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << DEC_LOG2) - 1);
  localparam logic signed [ADC_WIDTH-1:0] CMAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic signed [ADC_WIDTH-1:0] CMIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  logic [CW-1:0] r_cnt;
  logic          r_vld;
  logic          w_last, w_tready, w_acc, w_unused_guard;

  // With DEC_LOG2=0 the counter never leaves 0, so every beat is final.
  assign w_last   = (r_cnt == LAST);
  assign w_tready = adc_rstn && !(w_last && r_vld && !bus.M_AXIS_tready);
  assign w_acc    = bus.S_AXIS_tvalid && w_tready;
  assign w_unused_guard = ^bus.S_AXIS_tdata;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      if (w_acc) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (w_acc && w_last) r_vld <= 1'b1;
      else if (bus.M_AXIS_tready) r_vld <= 1'b0;
    end
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic signed [ADC_WIDTH-1:0] w_code, w_res;
    logic signed [AW-1:0]        w_sum, r_acc;
    logic signed [OUT_WIDTH-1:0] r_out;
    logic                        w_clip, r_flag;

    assign w_code = bus.S_AXIS_tdata[l*AXIS_DATA_WIDTH +: ADC_WIDTH];
    // Sum of 2^DEC_LOG2 codes always fits in AW bits; the mean fits back in ADC_WIDTH.
    assign w_sum  = r_acc + AW'(w_code);
    assign w_res  = ADC_WIDTH'(w_sum >>> DEC_LOG2);
    assign w_clip = (w_code == CMAX) || (w_code == CMIN);

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
      if (!adc_rstn) begin
        r_acc  <= '0;
        r_out  <= '0;
        r_flag <= 1'b0;
      end else begin
        if (w_acc) r_acc <= w_last ? '0 : w_sum;
        if (w_acc && w_last) r_out <= OUT_WIDTH'(w_res);
        r_flag <= (r_flag && !bus.clip_clear) || (w_acc && w_clip);
      end
    end

`ifdef PACKED_ADC_CLIP_COUNT_EN
    logic [31:0] r_ccnt;
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
      if (!adc_rstn) r_ccnt <= '0;
      else if (bus.clip_clear) r_ccnt <= {31'b0, w_acc && w_clip};
      else if (w_acc && w_clip && r_ccnt != 32'hFFFF_FFFF) r_ccnt <= r_ccnt + 32'd1;
    end
`endif
  end

  assign bus.S_AXIS_tready = w_tready;
  assign bus.M_AXIS_tvalid = r_vld;
  assign bus.M_AXIS_tdata  = {g_lane[1].r_out, g_lane[0].r_out};
  assign bus.clip_flags    = {g_lane[1].r_flag, g_lane[0].r_flag};
`ifdef PACKED_ADC_CLIP_COUNT_EN
  assign bus.clip_count_ch1 = g_lane[0].r_ccnt;
  assign bus.clip_count_ch2 = g_lane[1].r_ccnt;
`endif
endmodule

// File: doc/packed_adc_unpacker.md
# packed_adc_unpacker

- Receive-side counterpart of the packed 32-bit DAC word format (two sign-extended `ADC_WIDTH`-bit lanes in 16-bit halves).
- Accepts packed dual-channel ADC words on `adc_clk` and splits them into two signed lanes, sign-extended from bit `ADC_WIDTH-1`.
- Optionally block-averages 2^`DEC_LOG2` samples per lane and flags full-scale clipping.
- Presents a registered, backpressure-safe AXI-Stream output to the downstream RPSPMC signal chain (lock-in, filters, DMA).

## Interface
Parameters:
- `ADC_WIDTH`, 14, valid code bits per lane.
- `AXIS_DATA_WIDTH`, 16, lane pitch inside the input word.
- `AXIS_TDATA_WIDTH`, 32, input word width; equals 2*`AXIS_DATA_WIDTH`.
- `OUT_WIDTH`, 16, output lane width; must be ≥ `ADC_WIDTH`.
- `DEC_LOG2`, 0, log2 of the averaging block length. Range 0..8; 0 means pass-through.

Ports:
- `adc_clk`  in  1  sole clock.
- `adc_rstn`  in  1  asynchronous, active-low reset.
- `S_AXIS_tdata`  in  `AXIS_TDATA_WIDTH`  packed word. Lane 1 = [`ADC_WIDTH`-1:0]; lane 2 = [`AXIS_DATA_WIDTH`+`ADC_WIDTH`-1:`AXIS_DATA_WIDTH`].
- `S_AXIS_tvalid`  in  1  input beat valid.
- `S_AXIS_tready`  out  1  input beat accepted.
- `M_AXIS_tdata`  out  2*`OUT_WIDTH`  {lane2, lane1}, signed.
- `M_AXIS_tvalid`  out  1  output beat valid.
- `M_AXIS_tready`  in  1  downstream accept.
- `clip_clear`  in  1  one-cycle pulse; clears the clip flags and counters.
- `clip_flags`  out  2  sticky full-scale flags; bit0 = lane 1, bit1 = lane 2.
- `clip_count_ch1`, `clip_count_ch2`  out  32 each  only with `PACKED_ADC_CLIP_COUNT_EN`.

## Operation
- Input handshake:
  - A beat transfers when `S_AXIS_tvalid && S_AXIS_tready`.
  - Guard bits above `ADC_WIDTH-1` in each half are ignored.
- Lane extraction: each lane's `ADC_WIDTH`-bit code is sign-extended.
- Clip detection:
  - A lane clips when its code equals +2^(`ADC_WIDTH`-1)-1 or -2^(`ADC_WIDTH`-1).
  - Evaluated on every accepted beat.
  - Sets the sticky `clip_flags` bit for that lane.
- Accumulator:
  - Per lane, signed, width `ADC_WIDTH`+`DEC_LOG2`.
  - Beat counter `DEC_LOG2` bits wide, increments per accepted beat and wraps.
- Non-final beat (counter ≠ 2^`DEC_LOG2`-1):
  - acc ← acc + lane.
- Final beat (counter = 2^`DEC_LOG2`-1):
  - result = (acc + lane) >>> `DEC_LOG2`. Arithmetic shift, truncation toward -∞.
  - result is sign-extended to `OUT_WIDTH` and loaded into the output register.
  - acc ← 0 and counter ← 0.
  - With `DEC_LOG2`=0 every beat is a final beat.
- Output register: a single stage holding `M_AXIS_tdata` and `M_AXIS_tvalid`.
  - `M_AXIS_tvalid` sets on a final-beat load.
  - It clears on `M_AXIS_tready` when no new load happens in that cycle.
  - Load and drain in the same cycle keeps `M_AXIS_tvalid`=1 with the new data.
- `S_AXIS_tready` = `adc_rstn` && !(counter is final && `M_AXIS_tvalid` && !`M_AXIS_tready`).
  - This is combinational from `M_AXIS_tready`.
  - Non-final beats are never stalled.
- Stability: while `M_AXIS_tvalid`=1 and `M_AXIS_tready`=0, `M_AXIS_tdata` holds stable.
- Clip clear:
  - `clip_clear` zeroes the flags and counters on the next edge.
  - A clip on the same beat as `clip_clear` wins: the flag stays 1 and the counter becomes 1.

## Timing
- Reset values:
  - `M_AXIS_tvalid`=0, `M_AXIS_tdata`=0, `clip_flags`=0, counters=0.
  - Accumulators and beat counter = 0.
  - `S_AXIS_tready`=0 while `adc_rstn` is low.
- Reset mid-block: partial sums are discarded. The first beat after release starts a new block.
- Latency: final beat accepted at edge N → `M_AXIS_tvalid`=1 with its result after edge N.
- Throughput:
  - One input beat per cycle while downstream accepts.
  - One output per 2^`DEC_LOG2` input beats.
- Clip flags and counters update at the edge that accepts the beat.

## Configuration
- `PACKED_ADC_CLIP_COUNT_EN` defined:
  - `clip_count_ch1` and `clip_count_ch2` exist.
  - Each increments per clipped accepted beat, saturates at 0xFFFFFFFF, and is cleared by `clip_clear`.
- Undefined:
  - The counter ports and logic are absent.
  - `clip_flags` is still implemented.

## Test plan
- Sign extension and clip, `DEC_LOG2`=0:
  - Stimulus: input 0x1FFF_2000.
  - Response: next cycle `M_AXIS_tdata`=0x1FFF_E000 and `clip_flags`=2'b11. With the macro, both counters = 1.
- Guard-bit masking: input 0xC005_3FFE → output 0x0005_FFFE, `clip_flags` unchanged (0).
- Averaging, `DEC_LOG2`=2:
  - Stimulus: lane1 = 1,2,3,6 and lane2 = -1,-1,-1,-2 on consecutive beats.
  - Response: one output 0xFFFE_0003, `M_AXIS_tvalid` high only after the 4th beat.
- Backpressure, `DEC_LOG2`=0:
  - Stimulus: `M_AXIS_tready` held 0 for 5 cycles with `S_AXIS_tvalid`=1.
  - Response: `S_AXIS_tready`=0 after the first beat; output data stable; no beat lost or duplicated once `tready` returns to 1.
- Reset mid-block, `DEC_LOG2`=2:
  - Stimulus: 2 beats of lane1=100, assert `adc_rstn`=0, release, then 4 beats of lane1=8.
  - Response: first output lane1 = 8.
- Clip clear race: clipped beat and `clip_clear` on the same edge → `clip_flags` bit stays 1; counter = 1.
